// File: rtl/wdt_host_if.sv
// Host register front end for the watchdog timer: prescaler, control register, kick key FSM, status/W1C.
// Latency: register writes and pulses take effect one cycle after the write edge; reads return data one cycle after RdStrobe.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Ports:
//   LpcClock / PciReset        - LPC clock, asynchronous active-low reset
//   Addr, WrStrobe, WrData     - host write access (0=CTRL, 1=KICK, 2=STAT, 3=reserved)
//   Addr, RdStrobe -> RdData   - host read access, RdValid pulses with the returned data
//   WatchDog{Occurred,Reset,IREQ} - status from the timer, returned through STAT
//   Strobe125msec              - one-cycle time-base pulse every STROBE_DIV cycles
//   LoadWDTimer                - one-cycle timer reload (enable rising edge or valid kick)
//   WatchDogRegister           - control register: [7] lock, [4] enable, [3:0] timeout
//   ClearInterrupt             - one-cycle W1C pulses: [0] power, [1] reset, [2] watchdog
module wdt_host_if #(
  parameter int unsigned STROBE_DIV = 4125000,
  parameter logic [7:0]  KEY1       = 8'h55,
  parameter logic [7:0]  KEY2       = 8'hAA
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic [1:0] Addr,
  input  logic       WrStrobe,
  input  logic       RdStrobe,
  input  logic [7:0] WrData,
  output logic [7:0] RdData,
  output logic       RdValid,
  input  logic       WatchDogOccurred,
  input  logic       WatchDogReset,
  input  logic       WatchDogIREQ,
  output logic       Strobe125msec,
  output logic       LoadWDTimer,
  output logic [7:0] WatchDogRegister,
  output logic [2:0] ClearInterrupt
);

  localparam int unsigned        CW   = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam logic [CW-1:0]      LAST = CW'(STROBE_DIV - 1);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_KICK = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;

  typedef enum logic {S_IDLE, S_ARMED} kick_state_e;

  kick_state_e   state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q;
  logic [7:0]    ctrl_q;
  logic          load_q;
  logic [2:0]    clr_q;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q;

  logic wr_ctrl, wr_kick, wr_stat;
  logic ctrl_load, kick_load;

  assign wr_ctrl = WrStrobe && (Addr == A_CTRL);
  assign wr_kick = WrStrobe && (Addr == A_KICK);
  assign wr_stat = WrStrobe && (Addr == A_STAT);

  // Reload only on an accepted write that turns enable on, so the timer restarts from the new timeout.
  assign ctrl_load = wr_ctrl && !ctrl_q[7] && !ctrl_q[4] && WrData[4];
  assign kick_load = wr_kick && (state_q == S_ARMED) && (WrData == KEY2);

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // Read mux samples the pre-write state, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_data_d = 8'h00;
    case (Addr)
      A_CTRL:  rd_data_d = ctrl_q;
      A_KICK:  rd_data_d = {7'b0, (state_q == S_ARMED)};
      A_STAT:  rd_data_d = {3'b0, WatchDogOccurred, WatchDogReset, WatchDogIREQ, 2'b0};
      default: rd_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      ctrl_q     <= 8'h00;
      load_q     <= 1'b0;
      clr_q      <= 3'b000;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      // Registered so the strobe is high exactly while the counter sits at its last value.
      strobe_q <= (cnt_d == LAST);

      // Any write outside the key sequence breaks it; reads never touch it.
      if (WrStrobe) begin
        case (state_q)
          S_IDLE:  if (wr_kick && (WrData == KEY1)) state_q <= S_ARMED;
          S_ARMED: if (!(wr_kick && (WrData == KEY1))) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end

      // Bit 7 locks the register until the next reset.
      if (wr_ctrl && !ctrl_q[7]) ctrl_q <= WrData;

      load_q     <= ctrl_load || kick_load;
      clr_q      <= wr_stat ? WrData[2:0] : 3'b000;
      rd_valid_q <= RdStrobe;
      if (RdStrobe) rd_data_q <= rd_data_d;
    end
  end

  assign Strobe125msec    = strobe_q;
  assign LoadWDTimer      = load_q;
  assign WatchDogRegister = ctrl_q;
  assign ClearInterrupt   = clr_q;
  assign RdData           = rd_data_q;
  assign RdValid          = rd_valid_q;

endmodule

// File: tb/tb_wdt_host_if.sv
// Bench for wdt_host_if: directed scenarios followed by random register traffic, scored against an access-level model.
// Latency: each step drives one clock of inputs and checks the outputs 1 time unit after that edge.
// Backpressure: none; the design accepts every access.
module tb_wdt_host_if;

  localparam int unsigned DIV  = 10;
  localparam logic [7:0]  KEY1 = 8'h55;
  localparam logic [7:0]  KEY2 = 8'hAA;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wd;
  logic [7:0] rdata;
  logic       rvalid;
  logic       occ, wrst, ireq;
  logic       strobe;
  logic       load;
  logic [7:0] wreg;
  logic [2:0] clr;

  wdt_host_if #(.STROBE_DIV(DIV), .KEY1(KEY1), .KEY2(KEY2)) dut (
    .LpcClock         (clk),
    .PciReset         (rst_n),
    .Addr             (addr),
    .WrStrobe         (wr),
    .RdStrobe         (rd),
    .WrData           (wd),
    .RdData           (rdata),
    .RdValid          (rvalid),
    .WatchDogOccurred (occ),
    .WatchDogReset    (wrst),
    .WatchDogIREQ     (ireq),
    .Strobe125msec    (strobe),
    .LoadWDTimer      (load),
    .WatchDogRegister (wreg),
    .ClearInterrupt   (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state, described at the level of host-visible register semantics.
  logic [7:0] m_reg;
  logic       m_armed;
  logic [7:0] m_rdata;
  logic       m_rvalid;
  logic       m_load;
  logic [2:0] m_clr;
  int         k;          // clock edges since reset release
  int         hits[$];    // edge indices where a strobe was seen

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rdata"},  32'(rdata),  32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_strobe"}, 32'(strobe), 32'h0);
    chk({tag, "_load"},   32'(load),   32'h0);
    chk({tag, "_wreg"},   32'(wreg),   32'h0);
    chk({tag, "_clr"},    32'(clr),    32'h0);
  endtask

  task automatic model_reset();
    m_reg = 8'h00; m_armed = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
    m_load = 1'b0; m_clr = 3'b000; k = 0;
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs(tag);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: let the DUT take the current inputs, advance the model, compare everything.
  task automatic cycle();
    @(posedge clk); #1;
    k++;
    m_load = wr && (((addr == 2'd0) && !m_reg[7] && !m_reg[4] && wd[4]) ||
                    ((addr == 2'd1) && m_armed && (wd == KEY2)));
    m_clr    = (wr && (addr == 2'd2)) ? wd[2:0] : 3'b000;
    m_rvalid = rd;
    if (rd) begin
      case (addr)
        2'd0:    m_rdata = m_reg;
        2'd1:    m_rdata = {7'b0, m_armed};
        2'd2:    m_rdata = {3'b0, occ, wrst, ireq, 2'b0};
        default: m_rdata = 8'h00;
      endcase
    end
    if (wr && (addr == 2'd0) && !m_reg[7]) m_reg = wd;
    if (wr) m_armed = (addr == 2'd1) && (wd == KEY1);

    chk("strobe", 32'(strobe), 32'((k % DIV) == DIV - 1));
    chk("load",   32'(load),   32'(m_load));
    chk("clr",    32'(clr),    32'(m_clr));
    chk("wreg",   32'(wreg),   32'(m_reg));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata",  32'(rdata),  32'(m_rdata));
    if (strobe) hits.push_back(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr_op(input logic [1:0] a, input logic [7:0] d);
    addr = a; wd = d; wr = 1'b1;
    cycle();
    wr = 1'b0;
  endtask

  task automatic rd_op(input logic [1:0] a);
    addr = a; rd = 1'b1;
    cycle();
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 2'd0; wr = 1'b0; rd = 1'b0; wd = 8'h00;
    occ = 1'b0; wrst = 1'b0; ireq = 1'b0;
    model_reset();
    #2;
    do_reset("reset");

    // Time base with no register traffic.
    hits.delete();
    idle(35);
    chk("strobe_count", 32'(hits.size()), 32'd3);
    if (hits.size() == 3) begin
      chk("strobe_at_9",  32'(hits[0]), 32'd9);
      chk("strobe_at_19", 32'(hits[1]), 32'd19);
      chk("strobe_at_29", 32'(hits[2]), 32'd29);
    end

    // Enable rising edge reloads; rewriting with enable still set does not.
    wr_op(2'd0, 8'h13);
    chk("ctrl13_wreg", 32'(wreg), 32'h13);
    chk("ctrl13_load", 32'(load), 32'h1);
    idle(1);
    chk("ctrl13_load_drop", 32'(load), 32'h0);
    wr_op(2'd0, 8'h15);
    chk("ctrl15_wreg", 32'(wreg), 32'h15);
    chk("ctrl15_noload", 32'(load), 32'h0);

    // Kick key sequence, then a sequence broken by a STAT write.
    wr_op(2'd1, KEY1);
    rd_op(2'd1);
    chk("kick_armed_rd", 32'(rdata), 32'h1);
    wr_op(2'd1, KEY2);
    chk("kick_load", 32'(load), 32'h1);
    idle(1);
    wr_op(2'd1, KEY1);
    wr_op(2'd2, 8'h00);
    wr_op(2'd1, KEY2);
    chk("kick_broken_noload", 32'(load), 32'h0);
    rd_op(2'd1);
    chk("kick_broken_idle", 32'(rdata), 32'h0);

    // Lock holds the register until reset; after reset writes land again.
    wr_op(2'd0, 8'h9A);
    wr_op(2'd0, 8'h00);
    chk("lock_hold", 32'(wreg), 32'h9A);
    wr_op(2'd1, KEY1);
    do_reset("midreset");
    wr_op(2'd0, 8'h13);
    chk("post_reset_wreg", 32'(wreg), 32'h13);
    rd_op(2'd1);
    chk("post_reset_disarmed", 32'(rdata), 32'h0);

    // W1C pulses for exactly one cycle.
    wr_op(2'd2, 8'hFF);
    chk("stat_clr", 32'(clr), 32'h7);
    idle(1);
    chk("stat_clr_drop", 32'(clr), 32'h0);

    // Status read.
    ireq = 1'b1; wrst = 1'b1; occ = 1'b0;
    rd_op(2'd2);
    chk("stat_rvalid", 32'(rvalid), 32'h1);
    chk("stat_rdata",  32'(rdata),  32'h0C);
    idle(1);
    chk("stat_rvalid_drop", 32'(rvalid), 32'h0);
    chk("stat_rdata_hold",  32'(rdata),  32'h0C);

    // Read and write of CTRL in the same cycle returns the old value.
    addr = 2'd0; wd = 8'h05; wr = 1'b1; rd = 1'b1;
    cycle();
    wr = 1'b0; rd = 1'b0;
    chk("rw_same_cycle_old", 32'(rdata), 32'h13);
    chk("rw_same_cycle_new", 32'(wreg),  32'h05);

    // Random traffic, with occasional resets to reopen the lock.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 499) begin
        wr = 1'b0; rd = 1'b0;
        do_reset("rand_reset");
      end
      addr = 2'($urandom_range(0, 3));
      wr   = ($urandom_range(0, 9) < 4);
      rd   = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 3))
        0:       wd = KEY1;
        1:       wd = KEY2;
        default: wd = 8'($urandom) & (($urandom_range(0, 7) == 0) ? 8'hFF : 8'h7F);
      endcase
      occ  = 1'($urandom);
      wrst = 1'($urandom);
      ireq = 1'($urandom);
      cycle();
    end
    wr = 1'b0; rd = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
